// File: rtl/mfp_ahb_lite_master_pkg.sv
// Shared AHB-Lite encodings, slot record types and request normalisation helpers.
package mfp_ahb_lite_master_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic [2:0] HSIZE_BYTE = 3'b000;
  localparam logic [2:0] HSIZE_HALF = 3'b001;
  localparam logic [2:0] HSIZE_WORD = 3'b010;

  localparam logic [2:0] HBURST_SINGLE = 3'b000;

  localparam logic [1:0] SIZE_BYTE = 2'd0;
  localparam logic [1:0] SIZE_HALF = 2'd1;
  localparam logic [1:0] SIZE_WORD = 2'd2;

  // Request waiting for (or in) its address phase.
  typedef struct packed {
    logic        write;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
  } a_slot_t;

  // Transfer in its data phase; only the low address bits matter for lanes.
  typedef struct packed {
    logic        write;
    logic [1:0]  size;
    logic [1:0]  addr_lo;
    logic [31:0] wdata;
  } d_slot_t;

  // Size code 3 behaves as a word access everywhere downstream.
  function automatic logic [1:0] norm_size(input logic [1:0] size);
    return (size == 2'd3) ? SIZE_WORD : size;
  endfunction

  function automatic logic [31:0] align_addr(input logic [31:0] addr, input logic [1:0] size);
    logic [31:0] a;
    a = addr;
    case (size)
      SIZE_HALF: a[0] = 1'b0;
      SIZE_WORD: a[1:0] = 2'b00;
      default:   a = addr;
    endcase
    return a;
  endfunction

endpackage

// File: rtl/mfp_ahb_lite_master_lane.sv
// Byte-lane handling: replicate write data onto HWDATA, extract read data from HRDATA.
module mfp_ahb_lite_master_lane
  import mfp_ahb_lite_master_pkg::*;
(
  input  logic [1:0]  size,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] wdata,
  input  logic [31:0] hrdata,
  output logic [31:0] hwdata,
  output logic [31:0] rdata
);

  // Little-endian lane steering; size is already normalised (never 3).
  always_comb begin
    hwdata = wdata;
    rdata  = hrdata;
    case (size)
      SIZE_BYTE: begin
        hwdata = {4{wdata[7:0]}};
        rdata  = {24'b0, hrdata[{addr_lo, 3'b000} +: 8]};
      end
      SIZE_HALF: begin
        hwdata = {2{wdata[15:0]}};
        rdata  = {16'b0, hrdata[{addr_lo[1], 4'b0000} +: 16]};
      end
      default: begin
        hwdata = wdata;
        rdata  = hrdata;
      end
    endcase
  end

endmodule

// File: rtl/mfp_ahb_lite_master.sv
// AHB-Lite single-transfer master with a two-slot (address/data) pipeline.
module mfp_ahb_lite_master
  import mfp_ahb_lite_master_pkg::*;
#(
  parameter logic [3:0] HPROT_VAL = 4'b0011
) (
  input  logic        HCLK,
  input  logic        HRESETn,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [1:0]  req_size,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic        rsp_err,
  output logic [31:0] rsp_rdata,
  output logic [31:0] HADDR,
  output logic [2:0]  HBURST,
  output logic        HMASTLOCK,
  output logic [3:0]  HPROT,
  output logic [2:0]  HSIZE,
  output logic [1:0]  HTRANS,
  output logic [31:0] HWDATA,
  output logic        HWRITE,
  input  logic [31:0] HRDATA,
  input  logic        HREADY,
  input  logic        HRESP
);

  logic        a_vld_q, a_vld_d;
  a_slot_t     a_q, a_d;
  logic        d_vld_q, d_vld_d;
  d_slot_t     d_q, d_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic        rsp_err_q, rsp_err_d;
  logic [31:0] rsp_rdata_q, rsp_rdata_d;

  logic        accept;
  logic [1:0]  req_size_n;
  logic [31:0] lane_hwdata;
  logic [31:0] lane_rdata;

  assign req_ready  = !a_vld_q || HREADY;
  assign accept     = req_valid && req_ready;
  assign req_size_n = norm_size(req_size);

  mfp_ahb_lite_master_lane u_lane (
    .size    (d_q.size),
    .addr_lo (d_q.addr_lo),
    .wdata   (d_q.wdata),
    .hrdata  (HRDATA),
    .hwdata  (lane_hwdata),
    .rdata   (lane_rdata)
  );

  // Pipeline advance: HREADY moves address slot into data slot; acceptance refills address slot.
  always_comb begin
    a_vld_d = a_vld_q;
    a_d     = a_q;
    d_vld_d = d_vld_q;
    d_d     = d_q;
    if (HREADY) begin
      d_vld_d     = a_vld_q;
      d_d.write   = a_q.write;
      d_d.size    = a_q.size;
      d_d.addr_lo = a_q.addr[1:0];
      d_d.wdata   = a_q.wdata;
      a_vld_d     = 1'b0;
    end
    if (accept) begin
      a_vld_d  = 1'b1;
      a_d.write = req_write;
      a_d.size  = req_size_n;
      a_d.addr  = align_addr(req_addr, req_size_n);
      a_d.wdata = req_wdata;
    end
  end

  // Completion: a data phase ending with HREADY produces a one-cycle response next cycle.
  always_comb begin
    rsp_valid_d = d_vld_q && HREADY;
    rsp_err_d   = rsp_valid_d && HRESP;
    rsp_rdata_d = '0;
    if (rsp_valid_d && !HRESP && !d_q.write) rsp_rdata_d = lane_rdata;
  end

  // State registers.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      a_vld_q     <= 1'b0;
      a_q         <= '0;
      d_vld_q     <= 1'b0;
      d_q         <= '0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= '0;
    end else begin
      a_vld_q     <= a_vld_d;
      a_q         <= a_d;
      d_vld_q     <= d_vld_d;
      d_q         <= d_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
      rsp_rdata_q <= rsp_rdata_d;
    end
  end

  assign HTRANS    = a_vld_q ? HTRANS_NONSEQ : HTRANS_IDLE;
  assign HADDR     = a_q.addr;
  assign HWRITE    = a_q.write;
  assign HSIZE     = {1'b0, a_q.size};
  assign HBURST    = HBURST_SINGLE;
  assign HMASTLOCK = 1'b0;
  assign HPROT     = HPROT_VAL;
  assign HWDATA    = d_q.write ? lane_hwdata : 32'h0;

  assign rsp_valid = rsp_valid_q;
  assign rsp_err   = rsp_err_q;
  assign rsp_rdata = rsp_rdata_q;

endmodule

// File: tb/tb_mfp_ahb_lite_master.sv
// Bench for mfp_ahb_lite_master: queue-based transaction model plus directed literal checks.
module tb_mfp_ahb_lite_master;

  logic        HCLK;
  logic        HRESETn;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [31:0] req_addr;
  logic [1:0]  req_size;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic        rsp_err;
  logic [31:0] rsp_rdata;
  logic [31:0] HADDR;
  logic [2:0]  HBURST;
  logic        HMASTLOCK;
  logic [3:0]  HPROT;
  logic [2:0]  HSIZE;
  logic [1:0]  HTRANS;
  logic [31:0] HWDATA;
  logic        HWRITE;
  logic [31:0] HRDATA;
  logic        HREADY;
  logic        HRESP;

  int checks   = 0;
  int failures = 0;

  mfp_ahb_lite_master #(.HPROT_VAL(4'b0011)) dut (
    .HCLK      (HCLK),
    .HRESETn   (HRESETn),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_write (req_write),
    .req_addr  (req_addr),
    .req_size  (req_size),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid),
    .rsp_err   (rsp_err),
    .rsp_rdata (rsp_rdata),
    .HADDR     (HADDR),
    .HBURST    (HBURST),
    .HMASTLOCK (HMASTLOCK),
    .HPROT     (HPROT),
    .HSIZE     (HSIZE),
    .HTRANS    (HTRANS),
    .HWDATA    (HWDATA),
    .HWRITE    (HWRITE),
    .HRDATA    (HRDATA),
    .HREADY    (HREADY),
    .HRESP     (HRESP)
  );

  initial HCLK = 1'b0;
  always #5 HCLK = ~HCLK;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s at %0t: got 0x%08h expected 0x%08h", name, $time, act, exp);
    end
  endtask

  // Transaction-level model: a request lives in aq while waiting for its address
  // phase to be accepted by the bus, then in dq during its data phase.
  typedef struct {
    bit        write;
    int        size;
    bit [31:0] addr;
    bit [31:0] wdata;
  } req_t;

  req_t      aq[$];
  req_t      dq[$];
  bit        m_rsp_vld = 0;
  bit        m_rsp_err = 0;
  bit [31:0] m_rsp_rdata = 0;

  function automatic bit [31:0] model_rdata(bit [31:0] d, int sz, bit [31:0] addr);
    int lo;
    lo = int'(addr % 4);
    if (sz == 0) return (d >> (8 * lo)) & 32'hFF;
    if (sz == 1) return (d >> (16 * (lo / 2))) & 32'hFFFF;
    return d;
  endfunction

  function automatic bit [31:0] model_hwdata(bit [31:0] w, int sz);
    if (sz == 0) return (w & 32'hFF) * 32'h0101_0101;
    if (sz == 1) return (w & 32'hFFFF) * 32'h0001_0001;
    return w;
  endfunction

  always @(posedge HCLK or negedge HRESETn) begin
    req_t r;
    req_t n;
    bit   ready_now;
    if (!HRESETn) begin
      aq.delete();
      dq.delete();
      m_rsp_vld = 0;
      m_rsp_err = 0;
      m_rsp_rdata = 0;
    end else begin
      ready_now = (aq.size() == 0) || HREADY;
      m_rsp_vld = 0;
      m_rsp_err = 0;
      m_rsp_rdata = 0;
      if (HREADY) begin
        if (dq.size() > 0) begin
          r = dq.pop_front();
          m_rsp_vld = 1;
          m_rsp_err = HRESP;
          m_rsp_rdata = (HRESP || r.write) ? 32'h0 : model_rdata(HRDATA, r.size, r.addr);
        end
        if (aq.size() > 0) dq.push_back(aq.pop_front());
      end
      if (req_valid && ready_now) begin
        n.write = req_write;
        n.size  = (req_size == 2'd3) ? 2 : int'(req_size);
        n.addr  = req_addr & ~((32'd1 << n.size) - 32'd1);
        n.wdata = req_wdata;
        aq.push_back(n);
      end
    end
  end

  // Every-cycle comparison against the model while out of reset.
  always @(negedge HCLK) begin
    if (HRESETn) begin
      chk("req_ready", 32'(req_ready), 32'((aq.size() == 0) || HREADY));
      chk("htrans", 32'(HTRANS), (aq.size() > 0) ? 32'd2 : 32'd0);
      if (aq.size() > 0) begin
        chk("haddr", HADDR, aq[0].addr);
        chk("hwrite", 32'(HWRITE), 32'(aq[0].write));
        chk("hsize", 32'(HSIZE), 32'(aq[0].size));
      end
      chk("hburst", 32'(HBURST), 32'd0);
      chk("hprot", 32'(HPROT), 32'd3);
      chk("hmastlock", 32'(HMASTLOCK), 32'd0);
      if (dq.size() > 0 && dq[0].write)
        chk("hwdata", HWDATA, model_hwdata(dq[0].wdata, dq[0].size));
      chk("rsp_valid", 32'(rsp_valid), 32'(m_rsp_vld));
      if (m_rsp_vld) begin
        chk("rsp_err", 32'(rsp_err), 32'(m_rsp_err));
        chk("rsp_rdata", rsp_rdata, m_rsp_rdata);
      end
    end
  end

  task automatic step();
    @(posedge HCLK);
    #1;
  endtask

  task automatic mid();
    @(negedge HCLK);
  endtask

  task automatic set_req(input bit v, input bit w, input bit [31:0] a, input bit [1:0] s, input bit [31:0] d);
    req_valid = v;
    req_write = w;
    req_addr  = a;
    req_size  = s;
    req_wdata = d;
  endtask

  bit err_pend;

  initial begin
    HRESETn = 1'b0;
    HREADY  = 1'b1;
    HRESP   = 1'b0;
    HRDATA  = 32'h0;
    set_req(1, 0, 32'h100, 2, 32'h0);

    // Reset held with a request present: bus stays idle.
    repeat (3) begin
      mid();
      chk("rst_htrans", 32'(HTRANS), 32'd0);
      chk("rst_req_ready", 32'(req_ready), 32'd1);
      chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    end
    step();
    HRESETn = 1'b1;
    mid();
    chk("rel_htrans_idle", 32'(HTRANS), 32'd0);
    step();
    req_valid = 1'b0;
    mid();
    chk("rel_htrans_nonseq", 32'(HTRANS), 32'd2);
    repeat (3) step();

    // Zero-wait word write.
    set_req(1, 1, 32'h8000_0010, 2, 32'hDEAD_BEEF);
    mid();
    chk("wr_req_ready", 32'(req_ready), 32'd1);
    step();
    req_valid = 1'b0;
    mid();
    chk("wr_htrans", 32'(HTRANS), 32'd2);
    chk("wr_hwrite", 32'(HWRITE), 32'd1);
    chk("wr_hsize", 32'(HSIZE), 32'd2);
    chk("wr_haddr", HADDR, 32'h8000_0010);
    step();
    mid();
    chk("wr_hwdata", HWDATA, 32'hDEAD_BEEF);
    step();
    mid();
    chk("wr_rsp_valid", 32'(rsp_valid), 32'd1);
    chk("wr_rsp_err", 32'(rsp_err), 32'd0);
    step();

    // Byte read at offset 3, then halfword at offset 2.
    HRDATA = 32'hAABB_CCDD;
    set_req(1, 0, 32'hBF80_0003, 0, 32'h0);
    step();
    req_valid = 1'b0;
    mid();
    chk("rdb_haddr", HADDR, 32'hBF80_0003);
    chk("rdb_hsize", 32'(HSIZE), 32'd0);
    step();
    step();
    mid();
    chk("rdb_rdata", rsp_rdata, 32'h0000_00AA);
    set_req(1, 0, 32'hBF80_0002, 1, 32'h0);
    step();
    req_valid = 1'b0;
    repeat (2) step();
    mid();
    chk("rdh_rdata", rsp_rdata, 32'h0000_AABB);
    step();

    // Back-to-back reads with two wait states in the first data phase.
    set_req(1, 0, 32'h0, 2, 32'h0);
    step();
    req_addr = 32'h4;
    step();
    req_valid = 1'b0;
    HREADY = 1'b0;
    repeat (2) begin
      mid();
      chk("b2b_htrans", 32'(HTRANS), 32'd2);
      chk("b2b_haddr", HADDR, 32'h4);
      chk("b2b_req_ready", 32'(req_ready), 32'd0);
      chk("b2b_no_rsp", 32'(rsp_valid), 32'd0);
      step();
    end
    HREADY = 1'b1;
    HRDATA = 32'h1111_1111;
    step();
    HRDATA = 32'h2222_2222;
    mid();
    chk("b2b_a_rsp", 32'(rsp_valid), 32'd1);
    chk("b2b_a_rdata", rsp_rdata, 32'h1111_1111);
    step();
    mid();
    chk("b2b_b_rsp", 32'(rsp_valid), 32'd1);
    chk("b2b_b_rdata", rsp_rdata, 32'h2222_2222);
    step();

    // Slave error on a write with a read queued behind it.
    set_req(1, 1, 32'h20, 2, 32'hCAFE_F00D);
    step();
    set_req(1, 0, 32'h24, 2, 32'h0);
    step();
    req_valid = 1'b0;
    HREADY = 1'b0;
    HRESP  = 1'b1;
    mid();
    chk("err_haddr", HADDR, 32'h24);
    chk("err_hwdata", HWDATA, 32'hCAFE_F00D);
    step();
    HREADY = 1'b1;
    HRESP  = 1'b1;
    step();
    HRESP  = 1'b0;
    HRDATA = 32'h1234_5678;
    mid();
    chk("err_w_rsp", 32'(rsp_valid), 32'd1);
    chk("err_w_err", 32'(rsp_err), 32'd1);
    chk("err_w_rdata", rsp_rdata, 32'h0);
    step();
    mid();
    chk("err_r_rsp", 32'(rsp_valid), 32'd1);
    chk("err_r_err", 32'(rsp_err), 32'd0);
    chk("err_r_rdata", rsp_rdata, 32'h1234_5678);
    step();

    // Randomized traffic with wait states, two-cycle errors and junk HRESP when idle.
    err_pend = 0;
    for (int i = 0; i < 600; i++) begin
      req_valid = ($urandom_range(0, 99) < 60);
      req_write = 1'($urandom_range(0, 1));
      req_addr  = $urandom;
      req_size  = 2'($urandom_range(0, 3));
      req_wdata = $urandom;
      HRDATA    = $urandom;
      if (err_pend) begin
        HREADY = 1'b1;
        HRESP  = 1'b1;
        err_pend = 0;
      end else if (dq.size() > 0 && $urandom_range(0, 9) == 0) begin
        HREADY = 1'b0;
        HRESP  = 1'b1;
        err_pend = 1;
      end else begin
        HREADY = ($urandom_range(0, 3) != 0);
        HRESP  = (dq.size() == 0 && HREADY) ? 1'($urandom_range(0, 1)) : 1'b0;
      end
      step();
    end
    req_valid = 1'b0;
    HREADY = 1'b1;
    HRESP  = 1'b0;
    repeat (4) step();

    // Asynchronous reset in the middle of a stalled data phase.
    set_req(1, 1, 32'h44, 2, 32'h5555_AAAA);
    step();
    set_req(1, 0, 32'h48, 2, 32'h0);
    step();
    req_valid = 1'b0;
    HREADY = 1'b0;
    mid();
    #2;
    HRESETn = 1'b0;
    #1;
    chk("arst_htrans", 32'(HTRANS), 32'd0);
    chk("arst_haddr", HADDR, 32'h0);
    chk("arst_hwrite", 32'(HWRITE), 32'd0);
    chk("arst_hsize", 32'(HSIZE), 32'd0);
    chk("arst_hwdata", HWDATA, 32'h0);
    chk("arst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("arst_req_ready", 32'(req_ready), 32'd1);
    HREADY = 1'b1;
    repeat (2) step();
    HRESETn = 1'b1;
    repeat (4) begin
      mid();
      chk("arst_no_rsp", 32'(rsp_valid), 32'd0);
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
